gpu_cmd_engine: RTL and testbench

Parametrised next-generation GPU front end. It accepts 32-bit draw commands over an APB3 slave port and buffers them in a FIFO of configurable depth. It decodes the commands and sequences a downstream line rasteriser through a start/done handshake. Over the fixed-width first generation it adds command buffering, backpressure/overflow reporting, a status readback register, and a DRAW_RECT mode that expands into four line draws.

---
 rtl/gpu_pkg.sv | 48 ++++
 rtl/gpu_cmd_fifo.sv | 68 ++++++
 rtl/gpu_cmd_engine.sv | 275 +++++++++++++++++++++++++++
 tb/tb_gpu_cmd_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : gpu_pkg
// Brief    : Shared opcodes, FSM states, register map and rect corner helper
//            for the GPU command engine.
// Revision : 1.0 - initial release
//==============================================================================
package gpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_SET_P1    = 4'd1,
        OP_SET_P2    = 4'd2,
        OP_SET_COLOR = 4'd3,
        OP_DRAW_LINE = 4'd4,
        OP_DRAW_RECT = 4'd5
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    // Register map, decoded on paddr[3:2]
    localparam logic [1:0] C_ADDR_CMD    = 2'd0;
    localparam logic [1:0] C_ADDR_STATUS = 2'd1;

    localparam int C_STAT_BUSY      = 0;
    localparam int C_STAT_FULL      = 1;
    localparam int C_STAT_EMPTY     = 2;
    localparam int C_STAT_OVF       = 3;
    localparam int C_STAT_ILL       = 4;
    localparam int C_STAT_COUNT_LSB = 8;
    localparam int C_STAT_DRAWS_LSB = 16;

    // Corners numbered 0:(x1,y1) 1:(x2,y1) 2:(x2,y2) 3:(x1,y2); edge k runs
    // from corner k to corner k+1. Returns {use_x2, use_y2}.
    function automatic logic [1:0] rect_corner(input logic [1:0] edge_idx,
                                               input logic       end_pt);
        logic [1:0] k;
        k = edge_idx + {1'b0, end_pt};
        return {k[1] ^ k[0], k[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module   : gpu_cmd_fifo
// Brief    : Synchronous command FIFO with fall-through read data and
//            occupancy count.
// Revision : 1.0 - initial release
//==============================================================================
module gpu_cmd_fifo #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_BITS-1:0]         wdata,
    output logic [DATA_BITS-1:0]         rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_cmd_engine.sv
`default_nettype none
//==============================================================================
// Module   : gpu_cmd_engine
// Brief    : APB3 command front end; buffers draw commands and sequences a
//            line rasteriser, expanding rectangles into four line draws.
// Revision : 1.0 - initial release
//==============================================================================
module gpu_cmd_engine
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             paddr_i,
    input  logic [31:0]             pwdata_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    output logic [31:0]             prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [WIDTH_BITS-1:0]   x1_o,
    output logic [WIDTH_BITS-1:0]   x2_o,
    output logic [HEIGHT_BITS-1:0]  y1_o,
    output logic [HEIGHT_BITS-1:0]  y2_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    start_o,
    input  logic                    done_i,
    output logic                    busy_o
);

    localparam int W  = WIDTH_BITS;
    localparam int H  = HEIGHT_BITS;
    localparam int C  = CHANNEL_BITS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   w_rdata;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_apb_wr;
    logic          w_cmd_wr;
    logic          w_stat_wr;
    logic          w_stat_rd;
    logic          w_push;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_pop;
    logic          w_load_ep;
    logic [1:0]    w_sel_edge;
    logic          w_sel_rect;
    logic          w_draw_done;
    logic [3:0]    w_op;

    logic [31:0]   r_cmd;
    logic [W-1:0]  r_p1x, r_p2x, r_x1, r_x2;
    logic [H-1:0]  r_p1y, r_p2y, r_y1, r_y2;
    logic [C-1:0]  r_red, r_grn, r_blu;
    logic [1:0]    r_edge_idx;
    logic [1:0]    r_last_idx;
    logic          r_is_rect;
    logic [7:0]    r_draws;
    logic          r_ovf;
    logic          r_ill;

    logic [1:0]    w_c0;
    logic [1:0]    w_c1;
    logic [W-1:0]  w_ex1, w_ex2;
    logic [H-1:0]  w_ey1, w_ey2;
    logic          w_unused;

    assign w_apb_wr  = psel_i & penable_i & pwrite_i;
    assign w_cmd_wr  = w_apb_wr && (paddr_i[3:2] == C_ADDR_CMD);
    assign w_stat_wr = w_apb_wr && (paddr_i[3:2] == C_ADDR_STATUS);
    assign w_stat_rd = psel_i && !pwrite_i && (paddr_i[3:2] == C_ADDR_STATUS);
    // Full is judged before any same-cycle pop, so a full FIFO always drops
    assign w_push    = w_cmd_wr & ~w_full;
    assign pslverr_o = w_cmd_wr & w_full;
    assign pready_o  = 1'b1;
    assign w_op      = r_cmd[31:28];
    assign w_unused  = ^{paddr_i, r_cmd};

    gpu_cmd_fifo #(
        .DATA_BITS (32),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (pwdata_i),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_ep   = 1'b0;
        w_sel_edge  = 2'd0;
        w_sel_rect  = 1'b0;
        w_draw_done = 1'b0;
        start_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_op)
                    OP_DRAW_LINE: begin
                        w_load_ep   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                    OP_DRAW_RECT: begin
                        w_load_ep   = 1'b1;
                        w_sel_rect  = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            ST_ISSUE: begin
                start_o     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_i) begin
                    w_draw_done = 1'b1;
                    if (r_edge_idx == r_last_idx) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load_ep   = 1'b1;
                        w_sel_edge  = r_edge_idx + 2'd1;
                        w_sel_rect  = r_is_rect;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Endpoint selection for the edge about to be issued
    always_comb begin
        w_c0  = rect_corner(w_sel_edge, 1'b0);
        w_c1  = rect_corner(w_sel_edge, 1'b1);
        w_ex1 = r_p1x;
        w_ey1 = r_p1y;
        w_ex2 = r_p2x;
        w_ey2 = r_p2y;
        if (w_sel_rect) begin
            w_ex1 = w_c0[1] ? r_p2x : r_p1x;
            w_ey1 = w_c0[0] ? r_p2y : r_p1y;
            w_ex2 = w_c1[1] ? r_p2x : r_p1x;
            w_ey2 = w_c1[0] ? r_p2y : r_p1y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd      <= '0;
            r_p1x      <= '0;
            r_p1y      <= '0;
            r_p2x      <= '0;
            r_p2y      <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_x2       <= '0;
            r_y2       <= '0;
            r_red      <= '0;
            r_grn      <= '0;
            r_blu      <= '0;
            r_edge_idx <= '0;
            r_last_idx <= '0;
            r_is_rect  <= 1'b0;
            r_draws    <= '0;
            r_ovf      <= 1'b0;
            r_ill      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cmd <= w_rdata;
            end
            if (w_stat_wr && pwdata_i[C_STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_stat_wr && pwdata_i[C_STAT_ILL]) begin
                r_ill <= 1'b0;
            end
            if (pslverr_o) begin
                r_ovf <= 1'b1;
            end
            if (r_state == ST_DECODE) begin
                case (w_op)
                    OP_NOP: ;
                    OP_SET_P1: begin
                        r_p1x <= r_cmd[W-1:0];
                        r_p1y <= r_cmd[W+H-1:W];
                    end
                    OP_SET_P2: begin
                        r_p2x <= r_cmd[W-1:0];
                        r_p2y <= r_cmd[W+H-1:W];
                    end
                    OP_SET_COLOR: begin
                        r_red <= r_cmd[C-1:0];
                        r_grn <= r_cmd[2*C-1:C];
                        r_blu <= r_cmd[3*C-1:2*C];
                    end
                    OP_DRAW_LINE: begin
                        r_last_idx <= 2'd0;
                        r_is_rect  <= 1'b0;
                    end
                    OP_DRAW_RECT: begin
                        r_last_idx <= 2'd3;
                        r_is_rect  <= 1'b1;
                    end
                    default: r_ill <= 1'b1;
                endcase
            end
            if (w_load_ep) begin
                r_edge_idx <= w_sel_edge;
                r_x1       <= w_ex1;
                r_y1       <= w_ey1;
                r_x2       <= w_ex2;
                r_y2       <= w_ey2;
            end
            if (w_draw_done) begin
                r_draws <= r_draws + 8'd1;
            end
        end
    end

    always_comb begin
        prdata_o = '0;
        if (w_stat_rd) begin
            prdata_o[C_STAT_BUSY]                      = busy_o;
            prdata_o[C_STAT_FULL]                      = w_full;
            prdata_o[C_STAT_EMPTY]                     = w_empty;
            prdata_o[C_STAT_OVF]                       = r_ovf;
            prdata_o[C_STAT_ILL]                       = r_ill;
            prdata_o[C_STAT_COUNT_LSB+7:C_STAT_COUNT_LSB] = 8'(w_count);
            prdata_o[C_STAT_DRAWS_LSB+7:C_STAT_DRAWS_LSB] = r_draws;
        end
    end

    assign busy_o = (r_state != ST_IDLE) || !w_empty;
    assign x1_o   = r_x1;
    assign y1_o   = r_y1;
    assign x2_o   = r_x2;
    assign y2_o   = r_y2;
    assign r_o    = r_red;
    assign g_o    = r_grn;
    assign b_o    = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_gpu_cmd_engine
// Brief    : Directed bench for gpu_cmd_engine: line table, rect expansion,
//            queued SET ordering, illegal opcode, overflow and reset mid-draw.
// Revision : 1.0 - initial release
//==============================================================================
module tb_gpu_cmd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [9:0]  x1_o, x2_o;
    logic [8:0]  y1_o, y2_o;
    logic [7:0]  r_o, g_o, b_o;
    logic        start_o;
    logic        done_i = 1'b0;
    logic        busy_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    logic [7:0]  exp_draws = 8'd0;

    typedef struct {
        logic [31:0] p1_cmd;
        logic [31:0] p2_cmd;
        logic [31:0] col_cmd;
        logic [9:0]  ex1, ex2;
        logic [8:0]  ey1, ey2;
        logic [7:0]  er, eg, eb;
    } line_vec_t;

    typedef struct {
        logic [9:0] ex1, ex2;
        logic [8:0] ey1, ey2;
    } edge_vec_t;

    line_vec_t vecs [3];
    edge_vec_t rect_edges [4];

    gpu_cmd_engine dut (
        .clk       (clk),
        .rst       (rst),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .x1_o      (x1_o),
        .x2_o      (x2_o),
        .y1_o      (y1_o),
        .y2_o      (y2_o),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o),
        .start_o   (start_o),
        .done_i    (done_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_o) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // All tasks start and end at posedge+1
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic cmd(input logic [31:0] d);
        logic err;
        apb_write(32'h0, d, err);
        check("cmd_pslverr", 32'(err), 32'd0);
    endtask

    task automatic status_rd(input string nm, input logic [31:0] exp);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        #1 check(nm, prdata, exp);
        @(posedge clk); #1;
        psel = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int i;
        i = 0;
        while (!start_o && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check({nm, "_start"}, 32'(start_o), 32'd1);
    endtask

    task automatic check_ep(input string nm, input logic [9:0] ex1, input logic [8:0] ey1,
                            input logic [9:0] ex2, input logic [8:0] ey2);
        check({nm, "_x1"}, 32'(x1_o), 32'(ex1));
        check({nm, "_y1"}, 32'(y1_o), 32'(ey1));
        check({nm, "_x2"}, 32'(x2_o), 32'(ex2));
        check({nm, "_y2"}, 32'(y2_o), 32'(ey2));
    endtask

    task automatic one_cycle_start(input string nm);
        @(posedge clk); #1;
        check({nm, "_pulse_width"}, 32'(start_o), 32'd0);
    endtask

    task automatic pulse_done;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        exp_draws = exp_draws + 8'd1;
    endtask

    task automatic wait_idle(input string nm);
        int i;
        i = 0;
        while (busy_o && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        check({nm, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_x1"}, 32'(x1_o), 32'd0);
        check({nm, "_y1"}, 32'(y1_o), 32'd0);
        check({nm, "_x2"}, 32'(x2_o), 32'd0);
        check({nm, "_y2"}, 32'(y2_o), 32'd0);
        check({nm, "_rgb"}, {8'd0, r_o, g_o, b_o}, 32'd0);
        check({nm, "_start"}, 32'(start_o), 32'd0);
        check({nm, "_busy"}, 32'(busy_o), 32'd0);
        check({nm, "_pslverr"}, 32'(pslverr), 32'd0);
        check({nm, "_pready"}, 32'(pready), 32'd1);
    endtask

    initial begin
        logic err;
        int   s;

        // SET_P1/SET_P2 pack x in [9:0], y in [18:9+1]; colour r,g,b bytes
        vecs[0] = '{32'h1000_1003, 32'h2000_100A, 32'h3080_00FF,
                    10'd3, 10'd10, 9'd4, 9'd4, 8'hFF, 8'h00, 8'h80};
        vecs[1] = '{32'h1007_FFFF, 32'h2000_0000, 32'h3056_3412,
                    10'd1023, 10'd0, 9'd511, 9'd0, 8'h12, 8'h34, 8'h56};
        vecs[2] = '{32'h1804_0200, 32'h2000_0405, 32'h3F00_FF00,
                    10'd512, 10'd5, 9'd256, 9'd1, 8'h00, 8'hFF, 8'h00};

        rect_edges[0] = '{10'd1, 10'd5, 9'd2, 9'd2};
        rect_edges[1] = '{10'd5, 10'd5, 9'd2, 9'd6};
        rect_edges[2] = '{10'd5, 10'd1, 9'd6, 9'd6};
        rect_edges[3] = '{10'd1, 10'd1, 9'd6, 9'd2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");
        status_rd("reset_status", 32'h0000_0004);

        // Table of single line draws
        for (int v = 0; v < 3; v++) begin
            cmd(vecs[v].p1_cmd);
            cmd(vecs[v].p2_cmd);
            cmd(vecs[v].col_cmd);
            cmd(32'h4000_0000);
            wait_start($sformatf("line%0d", v));
            check_ep($sformatf("line%0d", v), vecs[v].ex1, vecs[v].ey1, vecs[v].ex2, vecs[v].ey2);
            check($sformatf("line%0d_rgb", v), {8'd0, r_o, g_o, b_o},
                  {8'd0, vecs[v].er, vecs[v].eg, vecs[v].eb});
            one_cycle_start($sformatf("line%0d", v));
            repeat (4) @(posedge clk);
            #1 check_ep($sformatf("line%0d_hold", v), vecs[v].ex1, vecs[v].ey1, vecs[v].ex2, vecs[v].ey2);
            pulse_done();
            check($sformatf("line%0d_busy_fall", v), 32'(busy_o), 32'd0);
            status_rd($sformatf("line%0d_status", v), {8'd0, exp_draws, 8'd0, 8'h04});
        end

        // Rectangle (1,2)-(5,6) expands to four edges
        cmd(32'h1000_0801);
        cmd(32'h2000_1805);
        cmd(32'h5000_0000);
        for (int e = 0; e < 4; e++) begin
            wait_start($sformatf("rect_e%0d", e));
            check_ep($sformatf("rect_e%0d", e), rect_edges[e].ex1, rect_edges[e].ey1,
                     rect_edges[e].ex2, rect_edges[e].ey2);
            one_cycle_start($sformatf("rect_e%0d", e));
            @(posedge clk); #1;
            pulse_done();
        end
        check("rect_busy_fall", 32'(busy_o), 32'd0);
        status_rd("rect_status", {8'd0, exp_draws, 8'd0, 8'h04});
        check("rect_draws", 32'(exp_draws), 32'd7);

        // SET_P1 queued behind a draw takes effect only for the next draw
        cmd(32'h4000_0000);
        cmd(32'h1000_1C07);
        wait_start("queued_a");
        check_ep("queued_a", 10'd1, 9'd2, 10'd5, 9'd6);
        @(posedge clk); #1;
        pulse_done();
        cmd(32'h4000_0000);
        wait_start("queued_b");
        check_ep("queued_b", 10'd7, 9'd7, 10'd5, 9'd6);
        @(posedge clk); #1;
        pulse_done();
        wait_idle("queued");

        // Illegal opcode: discarded, sticky ILL, next draw still runs
        s = start_cnt;
        cmd(32'hF000_0000);
        repeat (6) @(posedge clk);
        #1 check("ill_no_start", 32'(start_cnt), 32'(s));
        status_rd("ill_status", {8'd0, exp_draws, 8'd0, 8'h14});
        cmd(32'h4000_0000);
        wait_start("ill_next");
        check_ep("ill_next", 10'd7, 9'd7, 10'd5, 9'd6);
        @(posedge clk); #1;
        pulse_done();
        apb_write(32'h4, 32'h0000_0010, err);
        status_rd("ill_cleared", {8'd0, exp_draws, 8'd0, 8'h04});

        // Overflow with the rasteriser stalled mid-draw
        cmd(32'h4000_0000);
        wait_start("ovf_draw");
        for (int i = 0; i < 10; i++) begin
            apb_write(32'h0, 32'h0000_0000, err);
            check($sformatf("ovf_pslverr%0d", i), 32'(err), (i >= 8) ? 32'd1 : 32'd0);
        end
        status_rd("ovf_status", {8'd0, exp_draws, 8'd8, 8'h0B});
        apb_write(32'h4, 32'h0000_0008, err);
        status_rd("ovf_cleared", {8'd0, exp_draws, 8'd8, 8'h03});
        pulse_done();
        wait_idle("ovf_drain");
        status_rd("ovf_drained", {8'd0, exp_draws, 8'd0, 8'h04});

        // Reset in the WAIT of a rectangle abandons it
        cmd(32'h5000_0000);
        wait_start("rst_rect");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_draws = 8'd0;
        s = start_cnt;
        pulse_done();
        exp_draws = 8'd0;
        repeat (20) @(posedge clk);
        #1 check("rst_no_start", 32'(start_cnt), 32'(s));
        check_all_zero("rst_after");
        status_rd("rst_status", 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
